// File: rtl/uart_rx_if.sv
// Serial receive port bundle: line input plus the byte/strobe outputs toward the register stage.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (input rx, output data, valid, frame_err, busy);
    modport slave  (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid/frame_err strobes.
// Optional majority-vote glitch filter: define UART_RX_GLITCH_FILTER_EN.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned CNT_W = 11;
    localparam int unsigned MID   = CLKS_PER_BIT / 2;
`ifdef UART_RX_GLITCH_FILTER_EN
    // Vote window is target-1..target+1, so the decision lands one cycle late.
    localparam int unsigned START_AT = MID + 1;
`else
    localparam int unsigned START_AT = MID;
`endif
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_AT);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 3 || CLKS_PER_BIT > 2047) begin : g_bad_param
        $error("uart_rx: CLKS_PER_BIT must be in 3..2047");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_d;
    logic             rx_meta, rxs;
    logic [1:0]       sync_vld;
    logic             armed, armed_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bitn, bitn_d;
    logic [7:0]       shreg, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             sample_c, start_c;

    // Two-flop synchronizer; sync_vld marks when rxs reflects the real pin after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= bus.rx;
            rxs      <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] rxs_h;

    always_ff @(posedge clk) begin
        if (!rst) rxs_h <= 2'b11;
        else      rxs_h <= {rxs_h[0], rxs};
    end

    assign sample_c = (rxs_h[1] & rxs_h[0]) | (rxs_h[1] & rxs) | (rxs_h[0] & rxs);
    assign start_c  = ~rxs & ~rxs_h[0];
`else
    assign sample_c = rxs;
    assign start_c  = ~rxs;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            cnt     <= '0;
            bitn    <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            armed   <= armed_d;
            cnt     <= cnt_d;
            bitn    <= bitn_d;
            shreg   <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, counters and output strobes.
    always_comb begin
        state_d = state;
        armed_d = armed | (rxs & sync_vld[1]);
        cnt_d   = cnt + CNT_W'(1);
        bitn_d  = bitn;
        shreg_d = shreg;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (armed && start_c) state_d = S_START;
            end
            S_START: begin
                if (cnt == START_CNT) begin
                    cnt_d = '0;
                    if (sample_c) begin
                        state_d = S_IDLE;
                    end else begin
                        bitn_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_d   = '0;
                    shreg_d = {sample_c, shreg[7:1]};
                    if (bitn == 3'd7) state_d = S_STOP;
                    else              bitn_d  = bitn + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_d = '0;
                    if (sample_c) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
endmodule
